// File: rtl/ipf_sched_pkg.sv
// Shared types and constants for the IPF LCU command scheduler.
package ipf_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_ISSUE = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Filter type codes carried in the command word (3 also means edge offset)
   localparam logic [1:0] TYPE_OFF = 2'd0;
   localparam logic [1:0] TYPE_BO  = 2'd1;
   localparam logic [1:0] TYPE_WO  = 2'd2;

   // LCU size codes; code 3 behaves like 64
   localparam logic [1:0] SIZE_16 = 2'd0;
   localparam logic [1:0] SIZE_32 = 2'd1;
   localparam logic [1:0] SIZE_64 = 2'd2;

   // Command word layout: {type, band_pos, wo_class, offset}
   localparam int CMD_W      = 24;
   localparam int OFS_OFFSET = 0;
   localparam int OFS_WO     = 16;
   localparam int OFS_BAND   = 17;
   localparam int OFS_TYPE   = 22;

   // LCU grid width of the 128x128 image for a given size code
   function automatic logic [3:0] grid_w(input logic [1:0] size);
      case (size)
         SIZE_16: return 4'd8;
         SIZE_32: return 4'd4;
         default: return 4'd2;
      endcase
   endfunction

   // Highest grid coordinate for a given size code
   function automatic logic [2:0] grid_last(input logic [1:0] size);
      logic [3:0] g;
      g = grid_w(size) - 4'd1;
      return g[2:0];
   endfunction

endpackage

// File: rtl/ipf_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x W, async reset to empty.
// Push while full and pop while empty are ignored.
module ipf_cmd_fifo
   import ipf_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = CMD_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // Storage write; contents need no reset since count guards reads
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ipf_lcu_sched.sv
// IPF LCU command scheduler: queues host commands and issues one per LCU
// in raster order, waiting for the engine's done pulse between LCUs.
// Optional build macro IPF_SCHED_PREFETCH_EN: pop the next command in the
// same cycle as a non-final eng_done, skipping FETCH (one dead cycle).
// Handshake: a command is pushed on any clock edge where cfg_valid and
// cfg_ready are both high; cfg_ready is simply "FIFO not full".
module ipf_lcu_sched
   import ipf_sched_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        img_start,
   input  logic [1:0]  img_size,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [1:0]  cfg_type,
   input  logic [4:0]  cfg_band_pos,
   input  logic        cfg_wo_class,
   input  logic [15:0] cfg_offset,
   output logic        eng_start,
   output logic [1:0]  eng_type,
   output logic [4:0]  eng_band_pos,
   output logic        eng_wo_class,
   output logic [15:0] eng_offset,
   output logic [2:0]  eng_lcu_x,
   output logic [2:0]  eng_lcu_y,
   output logic [1:0]  eng_lcu_size,
   input  logic        eng_done,
   output logic        busy,
   output logic        img_done,
   output logic [6:0]  lcu_cnt,
   output logic        err,
   output logic [2:0]  dbg_state
);

   state_t          state, state_n;
   logic [CMD_W-1:0] cmd_q;
   logic [CMD_W-1:0] fifo_dout;
   logic            fifo_full, fifo_empty;
   logic            push, pop, pref_pop;
   logic [1:0]      size_q;
   logic [2:0]      nx, ny;
   logic [2:0]      adv_x, adv_y;
   logic [2:0]      gl;
   logic            last;

   assign cfg_ready = ~fifo_full;
   assign push      = cfg_valid & cfg_ready;
   assign dbg_state = state;

   ipf_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   ({cfg_type, cfg_band_pos, cfg_wo_class, cfg_offset}),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign eng_type     = cmd_q[OFS_TYPE +: 2];
   assign eng_band_pos = cmd_q[OFS_BAND +: 5];
   assign eng_wo_class = cmd_q[OFS_WO];
   assign eng_offset   = cmd_q[OFS_OFFSET +: 16];
   assign eng_lcu_size = size_q;

   // Raster successor of the LCU currently in the engine, and last-LCU test
   always_comb begin
      gl    = grid_last(size_q);
      adv_x = eng_lcu_x + 3'd1;
      adv_y = eng_lcu_y;
      if (eng_lcu_x == gl) begin
         adv_x = 3'd0;
         adv_y = eng_lcu_y + 3'd1;
      end
      last = (eng_lcu_x == gl) && (eng_lcu_y == gl);
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   // Next-state and strobe outputs
   always_comb begin
      state_n   = state;
      pop       = 1'b0;
      pref_pop  = 1'b0;
      eng_start = 1'b0;
      img_done  = 1'b0;
      busy      = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (img_start) state_n = S_FETCH;
         end
         S_FETCH: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_n = S_ISSUE;
            end
         end
         S_ISSUE: begin
            eng_start = 1'b1;
            state_n   = S_RUN;
         end
         S_RUN: begin
            if (eng_done) begin
               if (last) begin
                  state_n = S_DONE;
               end else begin
                  state_n = S_FETCH;
`ifdef IPF_SCHED_PREFETCH_EN
                  if (!fifo_empty) begin
                     pop      = 1'b1;
                     pref_pop = 1'b1;
                     state_n  = S_ISSUE;
                  end
`endif
               end
            end
         end
         S_DONE: begin
            img_done = 1'b1;
            state_n  = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Datapath: size latch, raster position, command register, counters, error
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         size_q    <= '0;
         nx        <= '0;
         ny        <= '0;
         cmd_q     <= '0;
         eng_lcu_x <= '0;
         eng_lcu_y <= '0;
         lcu_cnt   <= '0;
         err       <= 1'b0;
      end else begin
         if (state == S_IDLE && img_start) begin
            size_q  <= img_size;
            nx      <= 3'd0;
            ny      <= 3'd0;
            lcu_cnt <= '0;
         end
         if (state == S_RUN && eng_done) begin
            lcu_cnt <= lcu_cnt + 7'd1;
            if (!last) begin
               nx <= adv_x;
               ny <= adv_y;
            end
         end
         // Coordinates and parameters move together, only on a pop
         if (pop) begin
            cmd_q     <= fifo_dout;
            eng_lcu_x <= pref_pop ? adv_x : nx;
            eng_lcu_y <= pref_pop ? adv_y : ny;
         end
         if (eng_done && state != S_RUN) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ipf_lcu_sched.sv
// Directed testbench for ipf_lcu_sched (works with or without
// IPF_SCHED_PREFETCH_EN).
module tb_ipf_lcu_sched;
   import ipf_sched_pkg::*;

`ifdef IPF_SCHED_PREFETCH_EN
   localparam int EXP_GAP = 0;
`else
   localparam int EXP_GAP = 1;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        img_start = 1'b0;
   logic [1:0]  img_size = 2'd0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [1:0]  cfg_type = 2'd0;
   logic [4:0]  cfg_band_pos = 5'd0;
   logic        cfg_wo_class = 1'b0;
   logic [15:0] cfg_offset = 16'd0;
   logic        eng_start;
   logic [1:0]  eng_type;
   logic [4:0]  eng_band_pos;
   logic        eng_wo_class;
   logic [15:0] eng_offset;
   logic [2:0]  eng_lcu_x, eng_lcu_y;
   logic [1:0]  eng_lcu_size;
   logic        eng_done = 1'b0;
   logic        busy, img_done, err;
   logic [6:0]  lcu_cnt;
   logic [2:0]  dbg_state;

   int n_vec = 0;
   int n_err = 0;

   ipf_lcu_sched #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset), .img_start(img_start), .img_size(img_size),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_type(cfg_type),
      .cfg_band_pos(cfg_band_pos), .cfg_wo_class(cfg_wo_class),
      .cfg_offset(cfg_offset), .eng_start(eng_start), .eng_type(eng_type),
      .eng_band_pos(eng_band_pos), .eng_wo_class(eng_wo_class),
      .eng_offset(eng_offset), .eng_lcu_x(eng_lcu_x), .eng_lcu_y(eng_lcu_y),
      .eng_lcu_size(eng_lcu_size), .eng_done(eng_done), .busy(busy),
      .img_done(img_done), .lcu_cnt(lcu_cnt), .err(err), .dbg_state(dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] t, input logic [4:0] b,
                       input logic w, input logic [15:0] o);
      cfg_valid    = 1'b1;
      cfg_type     = t;
      cfg_band_pos = b;
      cfg_wo_class = w;
      cfg_offset   = o;
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic start_image(input logic [1:0] s);
      img_start = 1'b1;
      img_size  = s;
      step();
      img_start = 1'b0;
   endtask

   task automatic pulse_done();
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
   endtask

   // Steps until eng_start is seen; lat = steps taken (40 means timeout)
   task automatic wait_eng_start(output int lat);
      lat = 0;
      while (eng_start !== 1'b1 && lat < 40) begin
         step();
         lat++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      n_vec++;
      if (busy !== 1'b0 || eng_start !== 1'b0 || img_done !== 1'b0 || err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: busy=%b eng_start=%b img_done=%b err=%b, need all 0",
                  busy, eng_start, img_done, err);
      end
      n_vec++;
      if ({eng_type, eng_band_pos, eng_wo_class, eng_offset, eng_lcu_x, eng_lcu_y,
           eng_lcu_size, lcu_cnt} !== '0) begin
         n_err++;
         $display("FAIL reset_fields: type=%0d band=%0d wo=%b off=%h x=%0d y=%0d size=%0d cnt=%0d, need 0",
                  eng_type, eng_band_pos, eng_wo_class, eng_offset, eng_lcu_x, eng_lcu_y,
                  eng_lcu_size, lcu_cnt);
      end
      n_vec++;
      if (cfg_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_cfg_ready: got %b need 1", cfg_ready);
      end
      reset = 1'b0;
      step();
   endtask

   // Full FIFO, dropped 5th push, then a size-64 (2x2) image
   task automatic test_full_size2();
      int lat;
      for (int i = 0; i < 4; i++)
         push(TYPE_BO, 5'(3 + i), i[0], 16'h1000 + 16'(i));
      n_vec++;
      if (cfg_ready !== 1'b0) begin
         n_err++;
         $display("FAIL full_ready: got %b need 0", cfg_ready);
      end
      push(TYPE_WO, 5'd31, 1'b1, 16'hDEAD);
      start_image(2'd2);
      wait_eng_start(lat);
      n_vec++;
      if (lat !== 1) begin
         n_err++;
         $display("FAIL first_issue_latency: got %0d need 1", lat);
      end
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            wait_eng_start(lat);
            n_vec++;
            if (lat !== EXP_GAP) begin
               n_err++;
               $display("FAIL done_to_start_gap lcu%0d: got %0d need %0d", i, lat, EXP_GAP);
            end
         end
         n_vec++;
         if (eng_start !== 1'b1 || eng_lcu_x !== 3'(i % 2) || eng_lcu_y !== 3'(i / 2) ||
             eng_offset !== 16'h1000 + 16'(i) || eng_band_pos !== 5'(3 + i) ||
             eng_type !== TYPE_BO || eng_wo_class !== i[0] || eng_lcu_size !== 2'd2) begin
            n_err++;
            $display("FAIL size2_cmd lcu%0d: start=%b x=%0d y=%0d off=%h band=%0d type=%0d wo=%b size=%0d, need 1 %0d %0d %h %0d 1 %b 2",
                     i, eng_start, eng_lcu_x, eng_lcu_y, eng_offset, eng_band_pos, eng_type,
                     eng_wo_class, eng_lcu_size, i % 2, i / 2, 16'h1000 + 16'(i), 3 + i, i[0]);
         end
         step();
         step();
         pulse_done();
      end
      n_vec++;
      if (img_done !== 1'b1 || lcu_cnt !== 7'd4 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL size2_end: img_done=%b cnt=%0d busy=%b, need 1 4 1", img_done, lcu_cnt, busy);
      end
      step();
      n_vec++;
      if (busy !== 1'b0 || img_done !== 1'b0 || cfg_ready !== 1'b1 || err !== 1'b0) begin
         n_err++;
         $display("FAIL size2_idle: busy=%b img_done=%b cfg_ready=%b err=%b, need 0 0 1 0",
                  busy, img_done, cfg_ready, err);
      end
   endtask

   // Size 16 (8x8 grid): 64 LCUs, commands streamed in during RUN
   task automatic test_size0_raster();
      int lat;
      int next_push;
      int bad;
      bad = 0;
      for (int i = 0; i < 4; i++) push(TYPE_WO, 5'd0, 1'b0, 16'(i));
      next_push = 4;
      start_image(2'd0);
      wait_eng_start(lat);
      for (int i = 0; i < 64; i++) begin
         if (i > 0) begin
            wait_eng_start(lat);
            n_vec++;
            if (lat !== EXP_GAP) begin
               n_err++;
               $display("FAIL size0_gap lcu%0d: got %0d need %0d", i, lat, EXP_GAP);
            end
         end
         n_vec++;
         if (eng_start !== 1'b1 || eng_lcu_x !== 3'(i % 8) || eng_lcu_y !== 3'(i / 8) ||
             eng_offset !== 16'(i) || eng_lcu_size !== 2'd0) begin
            n_err++;
            bad++;
            if (bad < 6)
               $display("FAIL size0_cmd lcu%0d: start=%b x=%0d y=%0d off=%0d size=%0d, need 1 %0d %0d %0d 0",
                        i, eng_start, eng_lcu_x, eng_lcu_y, eng_offset, eng_lcu_size,
                        i % 8, i / 8, i);
         end
         if (next_push < 64) begin
            push(TYPE_WO, 5'd0, 1'b0, 16'(next_push));
            next_push++;
         end else begin
            step();
         end
         for (int k = 0; k < 4; k++) step();
         pulse_done();
      end
      n_vec++;
      if (img_done !== 1'b1 || lcu_cnt !== 7'd64) begin
         n_err++;
         $display("FAIL size0_end: img_done=%b cnt=%0d, need 1 64", img_done, lcu_cnt);
      end
      step();
      n_vec++;
      if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
         n_err++;
         $display("FAIL size0_idle: busy=%b cfg_ready=%b, need 0 1", busy, cfg_ready);
      end
   endtask

   // One command only: FSM must wait in FETCH until a second push
   task automatic test_starvation();
      int lat;
      push(TYPE_BO, 5'd7, 1'b1, 16'h5A5A);
      start_image(2'd2);
      wait_eng_start(lat);
      n_vec++;
      if (lat !== 1 || eng_lcu_x !== 3'd0 || eng_lcu_y !== 3'd0 || eng_offset !== 16'h5A5A) begin
         n_err++;
         $display("FAIL starve_first: lat=%0d x=%0d y=%0d off=%h, need 1 0 0 5a5a",
                  lat, eng_lcu_x, eng_lcu_y, eng_offset);
      end
      step();
      step();
      pulse_done();
      for (int c = 0; c < 6; c++) begin
         n_vec++;
         if (busy !== 1'b1 || eng_start !== 1'b0 || dbg_state !== S_FETCH) begin
            n_err++;
            $display("FAIL starve_hold cyc%0d: busy=%b eng_start=%b state=%0d, need 1 0 %0d",
                     c, busy, eng_start, dbg_state, S_FETCH);
         end
         // a stray img_start outside IDLE must change nothing
         img_start = (c == 2);
         img_size  = 2'd0;
         step();
         img_start = 1'b0;
      end
      n_vec++;
      if (eng_lcu_size !== 2'd2 || err !== 1'b0) begin
         n_err++;
         $display("FAIL stray_img_start: size=%0d err=%b, need 2 0", eng_lcu_size, err);
      end
      push(TYPE_WO, 5'd9, 1'b0, 16'h6B6B);
      n_vec++;
      if (eng_start !== 1'b0) begin
         n_err++;
         $display("FAIL starve_early_start: got %b need 0", eng_start);
      end
      step();
      n_vec++;
      if (eng_start !== 1'b1 || eng_lcu_x !== 3'd1 || eng_lcu_y !== 3'd0 || eng_offset !== 16'h6B6B) begin
         n_err++;
         $display("FAIL starve_resume: start=%b x=%0d y=%0d off=%h, need 1 1 0 6b6b",
                  eng_start, eng_lcu_x, eng_lcu_y, eng_offset);
      end
   endtask

   // Reset while in RUN with commands queued: everything returns to reset
   task automatic test_reset_in_run();
      step();
      push(TYPE_BO, 5'd1, 1'b0, 16'h0101);
      push(TYPE_BO, 5'd2, 1'b0, 16'h0202);
      n_vec++;
      if (dbg_state !== S_RUN || lcu_cnt !== 7'd1) begin
         n_err++;
         $display("FAIL pre_reset_run: state=%0d cnt=%0d, need %0d 1", dbg_state, lcu_cnt, S_RUN);
      end
      #2 reset = 1'b1;
      step();
      n_vec++;
      if (busy !== 1'b0 || eng_start !== 1'b0 || lcu_cnt !== 7'd0 || cfg_ready !== 1'b1 ||
          {eng_type, eng_band_pos, eng_wo_class, eng_offset, eng_lcu_x, eng_lcu_y,
           eng_lcu_size} !== '0) begin
         n_err++;
         $display("FAIL reset_in_run: busy=%b start=%b cnt=%0d ready=%b off=%h x=%0d y=%0d size=%0d, need 0 0 0 1 0 0 0 0",
                  busy, eng_start, lcu_cnt, cfg_ready, eng_offset, eng_lcu_x, eng_lcu_y,
                  eng_lcu_size);
      end
      reset = 1'b0;
      step();
      // FIFO must have been emptied: a new image starves in FETCH
      start_image(2'd1);
      for (int c = 0; c < 4; c++) begin
         n_vec++;
         if (eng_start !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL fifo_flushed cyc%0d: eng_start=%b busy=%b, need 0 1", c, eng_start, busy);
         end
         step();
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
   endtask

   // eng_done in IDLE sets sticky err; a size-code-3 image still runs 2x2
   task automatic test_err_idle();
      int lat;
      pulse_done();
      n_vec++;
      if (err !== 1'b1 || lcu_cnt !== 7'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL err_set: err=%b cnt=%0d busy=%b, need 1 0 0", err, lcu_cnt, busy);
      end
      for (int i = 0; i < 4; i++) push(TYPE_OFF, 5'd0, 1'b0, 16'h2000 + 16'(i));
      start_image(2'd3);
      for (int i = 0; i < 4; i++) begin
         wait_eng_start(lat);
         n_vec++;
         if (eng_start !== 1'b1 || eng_lcu_x !== 3'(i % 2) || eng_lcu_y !== 3'(i / 2) ||
             eng_offset !== 16'h2000 + 16'(i) || eng_lcu_size !== 2'd3 || err !== 1'b1) begin
            n_err++;
            $display("FAIL size3_cmd lcu%0d: start=%b x=%0d y=%0d off=%h size=%0d err=%b, need 1 %0d %0d %h 3 1",
                     i, eng_start, eng_lcu_x, eng_lcu_y, eng_offset, eng_lcu_size, err,
                     i % 2, i / 2, 16'h2000 + 16'(i));
         end
         step();
         pulse_done();
      end
      n_vec++;
      if (img_done !== 1'b1 || lcu_cnt !== 7'd4 || err !== 1'b1) begin
         n_err++;
         $display("FAIL size3_end: img_done=%b cnt=%0d err=%b, need 1 4 1", img_done, lcu_cnt, err);
      end
      step();
      n_vec++;
      if (busy !== 1'b0 || err !== 1'b1) begin
         n_err++;
         $display("FAIL err_sticky: busy=%b err=%b, need 0 1", busy, err);
      end
   endtask

   initial begin
      test_reset();
      test_full_size2();
      test_size0_raster();
      test_starvation();
      test_reset_in_run();
      test_err_idle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
